// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard/forwarding controller.
package ex_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_e;

endpackage

// File: rtl/ex_hazard_ctrl_fwd_sel_unit.sv
// Priority forwarding select for one EX operand.
module fwd_sel_unit
    import ex_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             en,
    input  logic [REG_W-1:0] src,
    input  logic             mem_wr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_wr,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_wr & (mem_rd != REG_W'(REG_ZERO)) & (mem_rd == src);
        wb_hit  = wb_wr & (wb_rd != REG_W'(REG_ZERO)) & (wb_rd == src);
        sel     = FWD_REG;
        // The younger producer in MEM wins over WB.
        if (!en)          sel = FWD_REG;
        else if (mem_hit) sel = FWD_EXMEM;
        else if (wb_hit)  sel = FWD_MEMWB;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage forwarding-select and load-use stall controller.
// Optional FWD_STATS_EN adds saturating stall/forward counters.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int REG_W = 5
`ifdef FWD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_alu_src,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             alu_src,
    output logic             stall,
    output logic             ex_bubble
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] fwd_count
`endif
);

    state_e state_q, state_d;

    logic             ex_valid_q, ex_valid_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memread_q, ex_memread_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic             ex_uses_rt_q, ex_uses_rt_d;
    logic             ex_alu_src_q, ex_alu_src_d;
    logic             mem_valid_q, mem_valid_d;
    logic             mem_regwrite_q, mem_regwrite_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic [REG_W-1:0] wb_rd_q, wb_rd_d;

    logic haz;
    logic take;

    fwd_sel_unit #(.REG_W(REG_W)) u_fwd_a (
        .en     (1'b1),
        .src    (ex_rs_q),
        .mem_wr (mem_valid_q & mem_regwrite_q),
        .mem_rd (mem_rd_q),
        .wb_wr  (wb_valid_q & wb_regwrite_q),
        .wb_rd  (wb_rd_q),
        .sel    (fwd_a)
    );

    fwd_sel_unit #(.REG_W(REG_W)) u_fwd_b (
        .en     (ex_uses_rt_q),
        .src    (ex_rt_q),
        .mem_wr (mem_valid_q & mem_regwrite_q),
        .mem_rd (mem_rd_q),
        .wb_wr  (wb_valid_q & wb_regwrite_q),
        .wb_rd  (wb_rd_q),
        .sel    (fwd_b)
    );

    always_comb begin
        haz = id_valid & ex_valid_q & ex_memread_q
            & (ex_rd_q != REG_W'(REG_ZERO))
            & ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));
        stall   = 1'b0;
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                stall = haz & ~flush & ~pipe_hold;
                if (stall) state_d = BUBBLE;
            end
            BUBBLE: begin
                if (!pipe_hold) state_d = RUN;
            end
        endcase
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_regwrite_d  = ex_regwrite_q;
        ex_memread_d   = ex_memread_q;
        ex_rd_d        = ex_rd_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_uses_rt_d   = ex_uses_rt_q;
        ex_alu_src_d   = ex_alu_src_q;
        mem_valid_d    = mem_valid_q;
        mem_regwrite_d = mem_regwrite_q;
        mem_rd_d       = mem_rd_q;
        wb_valid_d     = wb_valid_q;
        wb_regwrite_d  = wb_regwrite_q;
        wb_rd_d        = wb_rd_q;
        take           = id_valid & ~stall & ~flush;
        if (!pipe_hold) begin
            wb_valid_d     = mem_valid_q;
            wb_regwrite_d  = mem_regwrite_q;
            wb_rd_d        = mem_rd_q;
            mem_valid_d    = ex_valid_q;
            mem_regwrite_d = ex_regwrite_q;
            mem_rd_d       = ex_rd_q;
            // A bubble is fully zeroed so it can never match a forward.
            ex_valid_d     = take;
            ex_regwrite_d  = take & id_regwrite;
            ex_memread_d   = take & id_memread;
            ex_rd_d        = take ? id_rd : '0;
            ex_rs_d        = take ? id_rs : '0;
            ex_rt_d        = take ? id_rt : '0;
            ex_uses_rt_d   = take & id_uses_rt;
            ex_alu_src_d   = take & id_alu_src;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_uses_rt_q   <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= '0;
        end else begin
            state_q        <= state_d;
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_uses_rt_q   <= ex_uses_rt_d;
            ex_alu_src_q   <= ex_alu_src_d;
            mem_valid_q    <= mem_valid_d;
            mem_regwrite_q <= mem_regwrite_d;
            mem_rd_q       <= mem_rd_d;
            wb_valid_q     <= wb_valid_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    assign alu_src   = ex_alu_src_q;
    assign ex_bubble = (state_q == BUBBLE);

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] fwd_count_q, fwd_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (stall && !(&stall_count_q))
            stall_count_d = stall_count_q + 1'b1;
        if (!pipe_hold && ((fwd_a != FWD_REG) || (fwd_b != FWD_REG))
            && !(&fwd_count_q))
            fwd_count_d = fwd_count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Sequencing controller for the EX stage datapath: two 3:1 operand-forwarding muxes, the 2:1 immediate mux, and the ALU.
- Keeps its own copy of destination-register and control information for the EX, MEM and WB stages.
- From that state it drives the forwarding-mux selects, passes the immediate-select bit through, and detects load-use hazards.
- On a load-use hazard it asserts a one-cycle stall and inserts a bubble into EX.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, width of the statistics counters (only with FWD_STATS_EN).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_W  source register 1 of the ID instruction.
- id_rt  in  REG_W  source register 2 of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- id_rd  in  REG_W  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- id_alu_src  in  1  ID instruction uses the immediate as ALU operand B.
- pipe_hold  in  1  global freeze (memory wait); all state holds.
- flush  in  1  branch taken; the ID instruction is discarded.
- fwd_a  out  2  select for operand A mux: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  same encoding, for operand B mux.
- alu_src  out  1  select for the immediate mux, registered for the EX instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_bubble  out  1  EX currently holds an inserted bubble.

Behaviour:
- Reset (asynchronous, reset=0):
  - All tracking registers clear: ex/mem/wb valid, regwrite and memread = 0; rd/rs/rt = 0; ex_alu_src = 0.
  - State = RUN.
  - Outputs: fwd_a = fwd_b = 00, alu_src = 0, stall = 0, ex_bubble = 0.
- Tracking pipeline, advances on every rising edge when pipe_hold = 0:
  - WB takes MEM; MEM takes EX.
  - EX takes the ID fields when id_valid, !stall and !flush. Otherwise EX takes a bubble: valid, regwrite and memread = 0.
- pipe_hold = 1 freezes every register, including the FSM. stall is forced to 0 while held.
- Forwarding (combinational from registered state):
  - fwd_a = 01 if mem_regwrite & mem_rd != 0 & mem_rd == ex_rs.
  - Else fwd_a = 10 if wb_regwrite & wb_rd != 0 & wb_rd == ex_rs.
  - Else fwd_a = 00.
  - fwd_b uses the same rule with ex_rt. It is also forced to 00 when ex_uses_rt = 0.
  - EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- Load-use detection (combinational):
  - haz = id_valid & ex_memread & ex_rd != 0 & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- FSM states:
  - RUN: stall = haz & !flush & !pipe_hold. If stall, go to BUBBLE on the next edge.
  - BUBBLE: ex_bubble = 1 and stall = 0. The load is now in MEM, so the dependent instruction advances next cycle and receives fwd = 10. Go back to RUN unconditionally when not held.
- Simultaneous events:
  - flush and haz together: flush wins, no stall, and EX takes a bubble.
  - reset asserted mid-stall: immediate return to RUN with all outputs at their reset values.
- Latency:
  - Forwarding selects are valid in the same cycle the instruction occupies EX.
  - A load-use hazard costs exactly 1 bubble cycle.
  - alu_src follows the instruction into EX with 1-cycle latency.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined:
  - Adds outputs stall_count [CNT_W] and fwd_count [CNT_W], both reset to 0.
  - stall_count increments on each cycle with stall = 1.
  - fwd_count increments on each non-held cycle where fwd_a != 00 or fwd_b != 00. It increments by 1 even if both selects are non-zero.
  - Both counters saturate at all-ones.
- When undefined: the ports and logic do not exist, and the block is otherwise identical.

Decomposition:
- Shared package ex_ctrl_pkg holds:
  - forwarding encodings FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10;
  - FSM state type {RUN, BUBBLE};
  - REG_ZERO constant.
- One natural sub-module, fwd_sel_unit: the priority compare for a single operand, instantiated twice (A and B).

Test Plan:
- add $3 then add $4,$3,$5 back-to-back -> in the cycle the second add is in EX, fwd_a = 01, fwd_b = 00, stall = 0.
- add $3 ; nop ; sub $6,$2,$3 -> while sub is in EX, fwd_b = 10. Producer with rd = 0 -> fwd stays 00.
- lw $8 ; add $9,$8,$1 -> stall = 1 for exactly one cycle, then ex_bubble = 1, then add in EX with fwd_a = 10.
- lw $8 with flush = 1 while the dependent add is in ID -> stall = 0, EX takes a bubble, no forward.
- pipe_hold = 1 for 3 cycles during BUBBLE -> all outputs stable. reset = 0 mid-stall -> stall = 0 and fwd = 00 asynchronously.
- FWD_STATS_EN defined, 3 load-use pairs and 5 dependent adds -> stall_count = 3, fwd_count = 8.
